// File: rtl/core_mem_responder.sv
// Single-port memory responder for the 16-bit core: registered read, guarded writes,
// post-reset zero-fill of the frame region and an independent read-only scan port.
module core_mem_responder #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CLEAR_WORDS = 8000,
    parameter int unsigned PROG_BASE   = 9216
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] addrin,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    output logic [DATA_W-1:0] rdata,
    input  logic              protect,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    output logic              busy,
    output logic              drop_err
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [ADDR_W:0]   ClearLast = (ADDR_W+1)'(CLEAR_WORDS - 1);
    localparam logic [ADDR_W:0]   PtrOne    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ProgBase  = ADDR_W'(PROG_BASE);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clear_ptr_q, clear_ptr_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] scan_data_q;
    logic              scan_valid_q;
    logic              drop_err_q;

    logic              clear_wr;
    logic              core_wr;
    logic              drop;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] store [0:(1 << ADDR_W) - 1];

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        clear_wr    = 1'b0;
        core_wr     = 1'b0;
        drop        = 1'b0;
        unique case (state_q)
            StClear: begin
                clear_wr    = 1'b1;
                clear_ptr_d = clear_ptr_q + PtrOne;
                drop        = we;
                if (clear_ptr_q == ClearLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (we) begin
                    if (protect && (addrin >= ProgBase)) begin
                        drop = 1'b1;
                    end else begin
                        core_wr = 1'b1;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    // Clear engine owns the write port while busy; core writes are dropped then.
    always_comb begin
        mem_we    = clear_wr | core_wr;
        mem_waddr = clear_wr ? clear_ptr_q[ADDR_W-1:0] : addrin;
        mem_wdata = clear_wr ? '0 : wdata;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StClear;
            clear_ptr_q  <= '0;
            rdata_q      <= '0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_ptr_q  <= clear_ptr_d;
            rdata_q      <= store[addrin];
            scan_valid_q <= scan_req;
            if (scan_req) begin
                scan_data_q <= store[scan_addr];
            end
            if (drop) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    // Store has no reset so it can map onto block RAM; reads above see the pre-write word.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            store[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata      = rdata_q;
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;
    assign busy       = (state_q == StClear);
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench for core_mem_responder: directed scenarios plus random core/scan
// traffic checked against an array model of the store.
module tb_core_mem_responder;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int CLEAR_WORDS = 8000;
    localparam int PROG_BASE = 9216;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [ADDR_W-1:0] addrin = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              we = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic              protect = 1'b0;
    logic              scan_req = 1'b0;
    logic [ADDR_W-1:0] scan_addr = '0;
    logic [DATA_W-1:0] scan_data;
    logic              scan_valid;
    logic              busy;
    logic              drop_err;

    int n_checks = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] exp_scan_hold = '0;

    core_mem_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CLEAR_WORDS(CLEAR_WORDS),
        .PROG_BASE  (PROG_BASE)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .addrin    (addrin),
        .wdata     (wdata),
        .we        (we),
        .rdata     (rdata),
        .protect   (protect),
        .scan_req  (scan_req),
        .scan_addr (scan_addr),
        .scan_data (scan_data),
        .scan_valid(scan_valid),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        addrin = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        addrin = a; we = 1'b0;
        step();
        d = rdata;
    endtask

    // Edges from release until busy is seen low, bounded.
    task automatic count_clear(output int edges);
        edges = 0;
        for (int n = 1; n <= CLEAR_WORDS + 1000; n++) begin
            step();
            if (!busy) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
        n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_checks++; if (scan_valid !== 1'b0) begin n_fail++; $display("FAIL reset_scan_valid got %b want 0", scan_valid); end
        n_checks++; if (scan_data !== 16'h0) begin n_fail++; $display("FAIL reset_scan_data got %h want 0", scan_data); end
        n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop_err got %b want 0", drop_err); end
    endtask

    task automatic test_clear;
        int edges;
        resetn = 1'b1;
        count_clear(edges);
        n_checks++; if (edges !== CLEAR_WORDS) begin n_fail++; $display("FAIL clear_len got %0d want %0d", edges, CLEAR_WORDS); end
        n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL clear_no_drop got %b want 0", drop_err); end
    endtask

    task automatic test_rw;
        logic [DATA_W-1:0] d;
        write_word(15'd5, 16'h1234);
        read_word(15'd5, d);
        n_checks++; if (d !== 16'h1234) begin n_fail++; $display("FAIL rw_addr5 got %h want 1234", d); end
        write_word(15'd6, 16'hAAAA);
        addrin = 15'd6; wdata = 16'h5555; we = 1'b1;
        step();
        we = 1'b0;
        n_checks++; if (rdata !== 16'hAAAA) begin n_fail++; $display("FAIL rw_same_cycle got %h want aaaa", rdata); end
        read_word(15'd6, d);
        n_checks++; if (d !== 16'h5555) begin n_fail++; $display("FAIL rw_after got %h want 5555", d); end
    endtask

    task automatic test_restart;
        int edges;
        logic [DATA_W-1:0] d;
        write_word(15'd0, 16'h0101);
        write_word(15'd100, 16'h7777);
        write_word(15'd3999, 16'h3333);
        write_word(15'd7999, 16'h7999);
        write_word(15'd8000, 16'hC0DE);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        for (int i = 1; i <= 4000; i++) begin
            if (i == 50) begin addrin = 15'd100; wdata = 16'hFFFF; we = 1'b1; end
            step();
            we = 1'b0;
        end
        n_checks++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL clear_drop got %b want 1", drop_err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_clear_busy got %b want 1", busy); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL abort_drop_err got %b want 0", drop_err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b want 1", busy); end
        step();
        resetn = 1'b1;
        count_clear(edges);
        n_checks++; if (edges !== CLEAR_WORDS) begin n_fail++; $display("FAIL restart_len got %0d want %0d", edges, CLEAR_WORDS); end
        read_word(15'd0, d);
        n_checks++; if (d !== 16'h0) begin n_fail++; $display("FAIL cleared_0 got %h want 0", d); end
        read_word(15'd100, d);
        n_checks++; if (d !== 16'h0) begin n_fail++; $display("FAIL cleared_100 got %h want 0", d); end
        read_word(15'd3999, d);
        n_checks++; if (d !== 16'h0) begin n_fail++; $display("FAIL cleared_3999 got %h want 0", d); end
        read_word(15'd7999, d);
        n_checks++; if (d !== 16'h0) begin n_fail++; $display("FAIL cleared_7999 got %h want 0", d); end
        read_word(15'd8000, d);
        n_checks++; if (d !== 16'hC0DE) begin n_fail++; $display("FAIL kept_8000 got %h want c0de", d); end
        n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL restart_drop_err got %b want 0", drop_err); end
    endtask

    task automatic test_protect;
        logic [DATA_W-1:0] d;
        protect = 1'b0;
        write_word(15'(PROG_BASE), 16'h1111);
        write_word(15'(PROG_BASE - 1), 16'h2222);
        protect = 1'b1;
        write_word(15'(PROG_BASE - 1), 16'h3333);
        n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL below_base_drop got %b want 0", drop_err); end
        write_word(15'(PROG_BASE), 16'hBEEF);
        n_checks++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL protect_drop got %b want 1", drop_err); end
        read_word(15'(PROG_BASE), d);
        n_checks++; if (d !== 16'h1111) begin n_fail++; $display("FAIL protect_kept got %h want 1111", d); end
        read_word(15'(PROG_BASE - 1), d);
        n_checks++; if (d !== 16'h3333) begin n_fail++; $display("FAIL below_base got %h want 3333", d); end
        protect = 1'b0;
        write_word(15'(PROG_BASE), 16'hBEEF);
        read_word(15'(PROG_BASE), d);
        n_checks++; if (d !== 16'hBEEF) begin n_fail++; $display("FAIL unprotected got %h want beef", d); end
    endtask

    task automatic test_scan;
        logic [DATA_W-1:0] d;
        write_word(15'd0, 16'h0A0A);
        write_word(15'd1, 16'h0B0B);
        write_word(15'd2, 16'h0C0C);
        scan_req = 1'b1; scan_addr = 15'd0;
        step();
        n_checks++; if (scan_valid !== 1'b1 || scan_data !== 16'h0A0A) begin n_fail++; $display("FAIL scan0 got %b/%h want 1/0a0a", scan_valid, scan_data); end
        scan_addr = 15'd1; addrin = 15'd1; wdata = 16'hDDDD; we = 1'b1;
        step();
        we = 1'b0;
        n_checks++; if (scan_valid !== 1'b1 || scan_data !== 16'h0B0B) begin n_fail++; $display("FAIL scan1_old got %b/%h want 1/0b0b", scan_valid, scan_data); end
        scan_addr = 15'd2;
        step();
        n_checks++; if (scan_valid !== 1'b1 || scan_data !== 16'h0C0C) begin n_fail++; $display("FAIL scan2 got %b/%h want 1/0c0c", scan_valid, scan_data); end
        scan_req = 1'b0; scan_addr = 15'd0;
        step();
        n_checks++; if (scan_valid !== 1'b0 || scan_data !== 16'h0C0C) begin n_fail++; $display("FAIL scan_idle got %b/%h want 0/0c0c", scan_valid, scan_data); end
        exp_scan_hold = 16'h0C0C;
        read_word(15'd1, d);
        n_checks++; if (d !== 16'hDDDD) begin n_fail++; $display("FAIL scan_core_write got %h want dddd", d); end
    endtask

    function automatic logic [ADDR_W-1:0] pick();
        if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 31));
        return ADDR_W'(PROG_BASE + $urandom_range(0, 15));
    endfunction

    task automatic test_random;
        logic [DATA_W-1:0] model [int];
        logic [DATA_W-1:0] exp_r;
        logic [DATA_W-1:0] exp_s;
        logic exp_v;
        logic exp_drop;
        int a;
        protect = 1'b0; scan_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            model[i] = 16'($urandom);
            write_word(ADDR_W'(i), model[i]);
        end
        for (int i = PROG_BASE; i < PROG_BASE + 16; i++) begin
            model[i] = 16'($urandom);
            write_word(ADDR_W'(i), model[i]);
        end
        exp_s = exp_scan_hold;
        exp_drop = 1'b1;
        for (int n = 0; n < 400; n++) begin
            addrin = pick(); wdata = 16'($urandom);
            we = 1'($urandom_range(0, 1)); protect = 1'($urandom_range(0, 1));
            scan_req = 1'($urandom_range(0, 1)); scan_addr = pick();
            a = int'(addrin);
            exp_r = model[a];
            exp_v = scan_req;
            if (scan_req) exp_s = model[int'(scan_addr)];
            if (we) begin
                if (protect && a >= PROG_BASE) exp_drop = 1'b1;
                else model[a] = wdata;
            end
            step();
            n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL rand_rdata[%0d] got %h want %h", n, rdata, exp_r); end
            n_checks++; if (scan_valid !== exp_v) begin n_fail++; $display("FAIL rand_scan_valid[%0d] got %b want %b", n, scan_valid, exp_v); end
            n_checks++; if (scan_data !== exp_s) begin n_fail++; $display("FAIL rand_scan_data[%0d] got %h want %h", n, scan_data, exp_s); end
            n_checks++; if (drop_err !== exp_drop) begin n_fail++; $display("FAIL rand_drop_err[%0d] got %b want %b", n, drop_err, exp_drop); end
        end
        we = 1'b0; scan_req = 1'b0; protect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_rw();
        test_restart();
        test_protect();
        test_scan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
